// File: rtl/br_pred_gshare.sv
// Gshare branch predictor: PHT of 2-bit saturating counters indexed by PC ^ GHR.
// Combinational IF lookup, non-speculative training and statistics on ID resolution.
module br_pred_gshare #(
    parameter int          PHT_IDX_W = 6,
    parameter int          GHR_W     = 6,
    parameter logic [1:0]  CNT_INIT  = 2'b01,
    parameter int          STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 brch_instr_detectd_IF,
    input  logic [31:0]          pc_IF,
    output logic                 pred_taken_IF,
    output logic [PHT_IDX_W-1:0] pred_idx_IF,
    input  logic                 brch_instr_detectd_ID,
    input  logic                 brch_hazard_stall,
    input  logic                 actual_brch_result,
    input  logic [PHT_IDX_W-1:0] pred_idx_ID,
    input  logic                 pred_taken_ID,
    output logic                 mispredict_ID,
    output logic [STAT_W-1:0]    br_count,
    output logic [STAT_W-1:0]    mispred_count
);

    localparam int PHT_N = 1 << PHT_IDX_W;

    logic [1:0]           pht_q [PHT_N];
    logic [1:0]           pht_d [PHT_N];
    logic [GHR_W-1:0]     ghr_q, ghr_d, ghr_shift;
    logic [PHT_IDX_W-1:0] ghr_ext, lookup_idx;
    logic [STAT_W-1:0]    br_count_q, br_count_d;
    logic [STAT_W-1:0]    mispred_count_q, mispred_count_d;
    logic [1:0]           cnt_old;
    logic                 update;

    assign update = brch_instr_detectd_ID & ~brch_hazard_stall;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_W-1:0] = ghr_q;
    end

    // Reads come from the registered table, so a same-cycle update is not visible here.
    assign lookup_idx    = pc_IF[PHT_IDX_W+1:2] ^ ghr_ext;
    assign pred_idx_IF   = lookup_idx;
    assign pred_taken_IF = pht_q[lookup_idx][1] & brch_instr_detectd_IF;
    assign mispredict_ID = update & (actual_brch_result != pred_taken_ID);

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign ghr_shift = actual_brch_result;
        end else begin : g_ghr_multi
            assign ghr_shift = {ghr_q[GHR_W-2:0], actual_brch_result};
        end
    endgenerate

    assign cnt_old = pht_q[pred_idx_ID];

    always_comb begin
        pht_d           = pht_q;
        ghr_d           = ghr_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (update) begin
            if (actual_brch_result) begin
                if (cnt_old != 2'b11) pht_d[pred_idx_ID] = cnt_old + 2'd1;
            end else begin
                if (cnt_old != 2'b00) pht_d[pred_idx_ID] = cnt_old - 2'd1;
            end
            ghr_d = ghr_shift;
            if (~&br_count_q) br_count_d = br_count_q + STAT_W'(1);
            if (mispredict_ID && ~&mispred_count_q)
                mispred_count_d = mispred_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PHT_N; i++) pht_q[i] <= CNT_INIT;
            ghr_q           <= '0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            pht_q           <= pht_d;
            ghr_q           <= ghr_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

endmodule

// File: tb/tb_br_pred_gshare.sv
// Scoreboard bench for br_pred_gshare: directed cycles push hand-computed expectations,
// a negedge monitor pops and compares whenever a prediction, update or stats probe is presented.
module tb_br_pred_gshare;
    localparam int IW = 6;
    localparam int GW = 6;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          brch_instr_detectd_IF = 1'b0;
    logic [31:0]   pc_IF = '0;
    logic          pred_taken_IF;
    logic [IW-1:0] pred_idx_IF;
    logic          brch_instr_detectd_ID = 1'b0;
    logic          brch_hazard_stall = 1'b0;
    logic          actual_brch_result = 1'b0;
    logic [IW-1:0] pred_idx_ID = '0;
    logic          pred_taken_ID = 1'b0;
    logic          mispredict_ID;
    logic [SW-1:0] br_count;
    logic [SW-1:0] mispred_count;
    logic          probe_stats = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct packed { logic [IW-1:0] idx; logic taken; } pred_t;
    typedef struct packed { logic [SW-1:0] br; logic [SW-1:0] mis; } stat_t;
    pred_t pred_q[$];
    logic  misp_q[$];
    stat_t stat_q[$];
    pred_t pe;
    stat_t se;
    logic  me;

    br_pred_gshare #(.PHT_IDX_W(IW), .GHR_W(GW), .CNT_INIT(2'b01), .STAT_W(SW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .brch_instr_detectd_IF (brch_instr_detectd_IF),
        .pc_IF                 (pc_IF),
        .pred_taken_IF         (pred_taken_IF),
        .pred_idx_IF           (pred_idx_IF),
        .brch_instr_detectd_ID (brch_instr_detectd_ID),
        .brch_hazard_stall     (brch_hazard_stall),
        .actual_brch_result    (actual_brch_result),
        .pred_idx_ID           (pred_idx_ID),
        .pred_taken_ID         (pred_taken_ID),
        .mispredict_ID         (mispredict_ID),
        .br_count              (br_count),
        .mispred_count         (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (brch_instr_detectd_IF) begin
                if (pred_q.size() == 0) chk("pred_queue_underflow", 1, 0);
                else begin
                    pe = pred_q.pop_front();
                    chk("pred_idx_IF", int'(pred_idx_IF), int'(pe.idx));
                    chk("pred_taken_IF", int'(pred_taken_IF), int'(pe.taken));
                end
            end
            if (brch_instr_detectd_ID && !brch_hazard_stall) begin
                if (misp_q.size() == 0) chk("misp_queue_underflow", 1, 0);
                else begin
                    me = misp_q.pop_front();
                    chk("mispredict_ID", int'(mispredict_ID), int'(me));
                end
            end
            if (brch_instr_detectd_ID && brch_hazard_stall)
                chk("mispredict_ID_stalled", int'(mispredict_ID), 0);
            if (probe_stats) begin
                if (stat_q.size() == 0) chk("stat_queue_underflow", 1, 0);
                else begin
                    se = stat_q.pop_front();
                    chk("br_count", int'(br_count), int'(se.br));
                    chk("mispred_count", int'(mispred_count), int'(se.mis));
                end
            end
        end
    end

    task automatic if_look(input logic [31:0] pc, input logic [IW-1:0] eidx, input logic etk);
        brch_instr_detectd_IF = 1'b1;
        pc_IF = pc;
        pred_q.push_back('{idx: eidx, taken: etk});
    endtask

    task automatic id_upd(input logic [IW-1:0] idx, input logic act, input logic ptk,
                          input logic stall, input logic emisp);
        brch_instr_detectd_ID = 1'b1;
        pred_idx_ID = idx;
        actual_brch_result = act;
        pred_taken_ID = ptk;
        brch_hazard_stall = stall;
        if (!stall) misp_q.push_back(emisp);
    endtask

    task automatic stats(input logic [SW-1:0] ebr, input logic [SW-1:0] emis);
        probe_stats = 1'b1;
        stat_q.push_back('{br: ebr, mis: emis});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        brch_instr_detectd_IF = 1'b0;
        brch_instr_detectd_ID = 1'b0;
        brch_hazard_stall = 1'b0;
        probe_stats = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        #23 rst_n = 1'b1;
        tick();
        // reset state
        if_look(32'h40, 6'h10, 1'b0); stats(4'd0, 4'd0); tick();
        // training at 0x10: 01 -> 10 -> 11, then one not-taken -> 10; ghr ends 000110
        id_upd(6'h10, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        id_upd(6'h10, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'h4C, 6'h10, 1'b1); stats(4'd2, 4'd2); tick();
        id_upd(6'h10, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        if_look(32'h58, 6'h10, 1'b1); stats(4'd3, 4'd2); tick();
        if_look(32'h40, 6'h16, 1'b0); tick();
        // five not-taken at idx 5, IF watching idx 5 (pre-update value) each cycle
        if_look(32'h0C, 6'h05, 1'b0); id_upd(6'h05, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        if_look(32'h24, 6'h05, 1'b0); id_upd(6'h05, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        if_look(32'h74, 6'h05, 1'b0); id_upd(6'h05, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        if_look(32'hD4, 6'h05, 1'b0); id_upd(6'h05, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        if_look(32'h94, 6'h05, 1'b0); id_upd(6'h05, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        // five taken at idx 5: 00 -> 01 -> 10 -> 11 -> 11 -> 11
        if_look(32'h14, 6'h05, 1'b0); id_upd(6'h05, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'h10, 6'h05, 1'b0); id_upd(6'h05, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'h18, 6'h05, 1'b1); id_upd(6'h05, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'h08, 6'h05, 1'b1); id_upd(6'h05, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'h28, 6'h05, 1'b1); id_upd(6'h05, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'h68, 6'h05, 1'b1); stats(4'd13, 4'd7); tick();
        // stall three cycles (ghr = 0x1F), then release with same-cycle collision on 0x16
        for (int i = 0; i < 3; i++) begin
            if_look(32'h24, 6'h16, 1'b0); id_upd(6'h16, 1'b1, 1'b0, 1'b1, 1'b0); tick();
        end
        if_look(32'h24, 6'h16, 1'b0); id_upd(6'h16, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        if_look(32'hA4, 6'h16, 1'b1); stats(4'd14, 4'd8); tick();
        // statistics saturation
        id_upd(6'h20, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        stats(4'd15, 4'd9); tick();
        for (int i = 0; i < 19; i++) begin
            id_upd(6'h20, 1'b1, 1'b0, 1'b0, 1'b1); tick();
        end
        stats(4'd15, 4'd15); tick();
        id_upd(6'h20, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        stats(4'd15, 4'd15); tick();
        // asynchronous reset mid-cycle with an update in flight
        brch_instr_detectd_IF = 1'b1; pc_IF = 32'h40;
        brch_instr_detectd_ID = 1'b1; pred_idx_ID = 6'h10; actual_brch_result = 1'b0;
        pred_taken_ID = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_pred_idx_IF", int'(pred_idx_IF), 'h10);
        chk("async_rst_pred_taken_IF", int'(pred_taken_IF), 0);
        chk("async_rst_br_count", int'(br_count), 0);
        chk("async_rst_mispred_count", int'(mispred_count), 0);
        brch_instr_detectd_IF = 1'b0;
        brch_instr_detectd_ID = 1'b0;
        #1 rst_n = 1'b1;
        tick();
        stats(4'd0, 4'd0); tick();
        if_look(32'h40, 6'h10, 1'b0); tick();
        tick();
        chk("pred_queue_drained", pred_q.size(), 0);
        chk("misp_queue_drained", misp_q.size(), 0);
        chk("stat_queue_drained", stat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
